matmul_sequencer: RTL and testbench

Program sequencer for the N×N SIMD matrix datapath. It fetches 32-bit instructions from the instruction register file, decodes them, and drives row/column load strobes, MAC clear/enable with the K index, and write-back row handshakes. It replaces hand-driven control strobes, so a stored program can run load-B, load-A, MATMUL, write-back and END with no host intervention.

---
 rtl/matmul_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Program sequencer for the NxN SIMD matrix datapath: fetches, decodes and drives load/MAC/write-back strobes.
// Optional build macro MATSEQ_PERF_EN adds the PERF_CYCLES / PERF_STALLS counters (tied to 0 otherwise).
module matmul_sequencer #(
  parameter int N    = 16,
  parameter int REGN = 512,
  parameter int LogN = $clog2(N),
  parameter int PCW  = $clog2(REGN/2)
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START,
  output logic [PCW-1:0]  PC_INS,
  output logic            IMEM_REN,
  input  logic [31:0]     INSTRDATA,
  input  logic            DIN_VALID,
  output logic            DIN_READY,
  output logic            LOAD_A,
  output logic            LOAD_B,
  output logic [LogN-1:0] ROW_IDX,
  output logic            MAC_CLR,
  output logic            MAC_EN,
  output logic [LogN-1:0] K_IDX,
  output logic            WB_VALID,
  input  logic            WB_READY,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR,
  output logic [31:0]     PERF_CYCLES,
  output logic [31:0]     PERF_STALLS
);

  // state  | meaning
  // IDLE   | after reset, waiting for START
  // FETCH  | instruction read issued at PC
  // DECODE | opcode sampled, PC advanced
  // LOAD   | N operand row/column handshakes into MATA or MATB
  // MCLR   | accumulator clear
  // MAC    | N MAC steps, K_IDX 0..N-1
  // DRAIN  | final accumulator update settles
  // WB     | N result-row handshakes
  // HALT   | END reached, DONE held
  // ERROR  | illegal opcode or PC overflow, ERR held
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD, S_MCLR, S_MAC, S_DRAIN, S_WB, S_HALT, S_ERROR
  } state_t;

  localparam logic [7:0] OP_LOADB  = 8'h09;
  localparam logic [7:0] OP_LOADA  = 8'h0A;
  localparam logic [7:0] OP_MATMUL = 8'h03;
  localparam logic [7:0] OP_WB     = 8'h04;
  localparam logic [7:0] OP_END    = 8'h80;

  localparam logic [PCW-1:0]  PC_LAST  = PCW'(REGN/2 - 1);
  localparam logic [LogN-1:0] IDX_LAST = LogN'(N - 1);

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_d;
  logic [LogN-1:0] row_cnt_q, row_cnt_d, row_idx_d, k_idx_d;
  logic            load_a_sel_q, load_a_sel_d;
  logic            imem_ren_d, din_ready_d, load_a_d, load_b_d;
  logic            mac_clr_d, mac_en_d, wb_valid_d, busy_d, done_d, err_d;
  logic [7:0]      opcode;

  // Only the opcode byte is decoded; upper instruction bits are reserved.
  logic unused_instr_hi;
  assign unused_instr_hi = ^INSTRDATA[31:8];
  assign opcode = INSTRDATA[7:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = PC_INS;
    row_cnt_d    = row_cnt_q;
    row_idx_d    = ROW_IDX;
    k_idx_d      = K_IDX;
    load_a_sel_d = load_a_sel_q;
    done_d       = DONE;
    err_d        = ERR;
    load_a_d     = 1'b0;
    load_b_d     = 1'b0;

    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (START) begin
          state_d = S_FETCH;
          pc_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        pc_d = (PC_INS == PC_LAST) ? PC_INS : PC_INS + 1'b1;
        if (opcode == OP_END) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (PC_INS == PC_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          case (opcode)
            OP_LOADA, OP_LOADB: begin
              state_d      = S_LOAD;
              row_cnt_d    = '0;
              row_idx_d    = '0;
              load_a_sel_d = (opcode == OP_LOADA);
            end
            OP_MATMUL: begin
              state_d = S_MCLR;
              k_idx_d = '0;
            end
            OP_WB: begin
              state_d   = S_WB;
              row_idx_d = '0;
            end
            default: begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        // DIN_READY is high throughout LOAD, so DIN_VALID alone marks a handshake.
        // The strobe is registered, so ROW_IDX is set to the row it refers to.
        if (DIN_VALID) begin
          load_a_d  = load_a_sel_q;
          load_b_d  = !load_a_sel_q;
          row_idx_d = row_cnt_q;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == IDX_LAST) state_d = S_FETCH;
        end
      end
      S_MCLR: begin
        state_d = S_MAC;
        k_idx_d = '0;
      end
      S_MAC: begin
        k_idx_d = K_IDX + 1'b1;
        if (K_IDX == IDX_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_FETCH;
      S_WB: begin
        if (WB_READY) begin
          row_idx_d = ROW_IDX + 1'b1;
          if (ROW_IDX == IDX_LAST) state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    imem_ren_d  = (state_d == S_FETCH);
    din_ready_d = (state_d == S_LOAD);
    mac_clr_d   = (state_d == S_MCLR);
    mac_en_d    = (state_d == S_MAC);
    wb_valid_d  = (state_d == S_WB);
    busy_d      = !(state_d inside {S_IDLE, S_HALT, S_ERROR});
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= S_IDLE;
      PC_INS       <= '0;
      row_cnt_q    <= '0;
      load_a_sel_q <= 1'b0;
      ROW_IDX      <= '0;
      K_IDX        <= '0;
      IMEM_REN     <= 1'b0;
      DIN_READY    <= 1'b0;
      LOAD_A       <= 1'b0;
      LOAD_B       <= 1'b0;
      MAC_CLR      <= 1'b0;
      MAC_EN       <= 1'b0;
      WB_VALID     <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      state_q      <= state_d;
      PC_INS       <= pc_d;
      row_cnt_q    <= row_cnt_d;
      load_a_sel_q <= load_a_sel_d;
      ROW_IDX      <= row_idx_d;
      K_IDX        <= k_idx_d;
      IMEM_REN     <= imem_ren_d;
      DIN_READY    <= din_ready_d;
      LOAD_A       <= load_a_d;
      LOAD_B       <= load_b_d;
      MAC_CLR      <= mac_clr_d;
      MAC_EN       <= mac_en_d;
      WB_VALID     <= wb_valid_d;
      BUSY         <= busy_d;
      DONE         <= done_d;
      ERR          <= err_d;
    end
  end

`ifdef MATSEQ_PERF_EN
  logic perf_clr, perf_stall;
  assign perf_clr   = START && (state_q inside {S_IDLE, S_HALT, S_ERROR});
  assign perf_stall = (state_q == S_LOAD && !DIN_VALID) || (state_q == S_WB && !WB_READY);

  // BUSY mirrors the current state, so it gates the cycle counter directly.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PERF_CYCLES <= '0;
      PERF_STALLS <= '0;
    end else if (perf_clr) begin
      PERF_CYCLES <= '0;
      PERF_STALLS <= '0;
    end else begin
      if (BUSY && PERF_CYCLES != 32'hFFFF_FFFF) PERF_CYCLES <= PERF_CYCLES + 1'b1;
      if (perf_stall && PERF_STALLS != 32'hFFFF_FFFF) PERF_STALLS <= PERF_STALLS + 1'b1;
    end
  end
`else
  assign PERF_CYCLES = '0;
  assign PERF_STALLS = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed self-checking bench for matmul_sequencer: full program, stalled loads, illegal opcode,
// mid-MAC reset and PC overflow. Honours MATSEQ_PERF_EN for the performance-counter expectations.
module tb_matmul_sequencer;

`ifdef MATSEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK, RSTN, START;
  logic [7:0]  PC_INS;
  logic        IMEM_REN;
  logic [31:0] INSTRDATA;
  logic        DIN_VALID, DIN_READY, LOAD_A, LOAD_B;
  logic [3:0]  ROW_IDX, K_IDX;
  logic        MAC_CLR, MAC_EN, WB_VALID, WB_READY, BUSY, DONE, ERR;
  logic [31:0] PERF_CYCLES, PERF_STALLS;

  logic [31:0] imem [0:255];

  int checks = 0;
  int errors = 0;
  int cyc, busy, lb, la, clr, mac, wb, kerr, rowerr, order_err, first_rdy, stalls, maxpc;

  matmul_sequencer dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .PC_INS(PC_INS), .IMEM_REN(IMEM_REN),
    .INSTRDATA(INSTRDATA), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .LOAD_A(LOAD_A), .LOAD_B(LOAD_B), .ROW_IDX(ROW_IDX), .MAC_CLR(MAC_CLR),
    .MAC_EN(MAC_EN), .K_IDX(K_IDX), .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .PERF_CYCLES(PERF_CYCLES), .PERF_STALLS(PERF_STALLS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: read data appears the cycle after IMEM_REN.
  initial INSTRDATA = '0;
  always @(posedge CLK) if (IMEM_REN) INSTRDATA <= imem[PC_INS];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {6'd0, PC_INS, IMEM_REN, DIN_READY, LOAD_A, LOAD_B, ROW_IDX,
            MAC_CLR, MAC_EN, K_IDX, WB_VALID, BUSY, DONE, ERR};
  endfunction

  function automatic logic [31:0] strobes();
    return {25'd0, IMEM_REN, DIN_READY, LOAD_A, LOAD_B, MAC_CLR, MAC_EN, WB_VALID};
  endfunction

  initial begin
    RSTN = 1'b1; START = 1'b0; DIN_VALID = 1'b0; WB_READY = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    #1 RSTN = 1'b0;
    tick(); tick();
    chk("reset_outputs", all_outs(), 32'd0);
    chk("reset_perf", PERF_CYCLES | PERF_STALLS, 32'd0);
    RSTN = 1'b1;
    tick(); tick(); tick();
    chk("idle_no_start", all_outs(), 32'd0);

    // Full program, no stalls
    imem[0] = 32'h09; imem[1] = 32'h0A; imem[2] = 32'h03; imem[3] = 32'h04; imem[4] = 32'h80;
    DIN_VALID = 1'b1; WB_READY = 1'b1;
    pulse_start();
    chk("fetch_pc0", {IMEM_REN, BUSY, PC_INS}, {1'b1, 1'b1, 8'd0});
    cyc = 0; busy = 0; lb = 0; la = 0; clr = 0; mac = 0; wb = 0;
    kerr = 0; rowerr = 0; order_err = 0; first_rdy = -1;
    while (!DONE && cyc < 300) begin
      if (BUSY) busy++;
      if (DIN_READY && first_rdy < 0) first_rdy = cyc;
      if (LOAD_B) lb++;
      if (LOAD_A) begin if (lb != 16) order_err++; la++; end
      if (MAC_CLR) begin if (la != 16) order_err++; clr++; end
      if (MAC_EN) begin if (K_IDX !== mac[3:0]) kerr++; mac++; end
      if (WB_VALID && WB_READY) begin
        if (ROW_IDX !== wb[3:0]) rowerr++;
        if (mac != 16) order_err++;
        wb++;
      end
      tick(); cyc++;
    end
    chk("prog_done", {DONE, ERR, BUSY}, {1'b1, 1'b0, 1'b0});
    chk("first_ready_latency", first_rdy, 2);
    chk("loadb_pulses", lb, 16);
    chk("loada_pulses", la, 16);
    chk("mac_clr_count", clr, 1);
    chk("mac_en_count", mac, 16);
    chk("k_idx_sequence", kerr, 0);
    chk("wb_rows", wb, 16);
    chk("wb_row_idx", rowerr, 0);
    chk("phase_order", order_err, 0);
    chk("busy_cycles", busy, 76);
    chk("perf_cycles_prog", PERF_CYCLES, PERF ? 32'd76 : 32'd0);
    chk("perf_stalls_prog", PERF_STALLS, 32'd0);

    // LOADA with DIN_VALID alternating, starting low in the first LOAD cycle
    imem[0] = 32'h0A; imem[1] = 32'h80;
    pulse_start();
    DIN_VALID = 1'b0;
    tick();
    tick();
    cyc = 0; stalls = 0; la = 0; lb = 0; rowerr = 0;
    while (DIN_READY && cyc < 100) begin
      cyc++;
      if (!DIN_VALID) stalls++;
      tick();
      if (LOAD_A) begin if (ROW_IDX !== la[3:0]) rowerr++; la++; end
      if (LOAD_B) lb++;
      DIN_VALID = !DIN_VALID;
    end
    chk("stall_load_cycles", cyc, 32);
    chk("stall_count", stalls, 16);
    chk("stall_loada_pulses", {lb[15:0], la[15:0]}, 32'd16);
    chk("stall_row_idx", rowerr, 0);
    cyc = 0;
    while (!DONE && cyc < 20) begin tick(); cyc++; end
    chk("stall_done", DONE, 1'b1);
    chk("perf_stalls_loada", PERF_STALLS, PERF ? 32'd16 : 32'd0);
    chk("perf_cycles_loada", PERF_CYCLES, PERF ? 32'd36 : 32'd0);

    // Illegal opcode at PC 2, then restart
    imem[0] = 32'h09; imem[1] = 32'h03; imem[2] = 32'h55; imem[3] = 32'h80;
    DIN_VALID = 1'b1;
    pulse_start();
    cyc = 0;
    while (!ERR && cyc < 200) begin tick(); cyc++; end
    chk("illegal_err", {ERR, DONE, BUSY}, {1'b1, 1'b0, 1'b0});
    tick(); tick(); tick();
    chk("error_no_strobes", strobes(), 32'd0);
    chk("error_sticky", ERR, 1'b1);
    imem[2] = 32'h80;
    pulse_start();
    chk("restart_pc0_err_clr", {ERR, IMEM_REN, PC_INS}, {1'b0, 1'b1, 8'd0});
    cyc = 0;
    while (!DONE && cyc < 200) begin tick(); cyc++; end
    chk("restart_done", {DONE, ERR}, {1'b1, 1'b0});

    // Asynchronous reset in the middle of MAC
    imem[0] = 32'h03; imem[1] = 32'h80;
    pulse_start();
    cyc = 0;
    while (!(MAC_EN && K_IDX == 4'd7) && cyc < 50) begin tick(); cyc++; end
    chk("reached_mac_k7", {MAC_EN, K_IDX}, {1'b1, 4'd7});
    #2 RSTN = 1'b0;
    #1;
    chk("async_reset_mac_en", MAC_EN, 1'b0);
    chk("async_reset_outputs", all_outs(), 32'd0);
    tick(); tick();
    RSTN = 1'b1;
    tick(); tick();
    chk("post_reset_idle", {BUSY, IMEM_REN, PC_INS}, 32'd0);

    // PC overflow: every word is LOADB, no END
    for (int i = 0; i < 256; i++) imem[i] = 32'h09;
    DIN_VALID = 1'b1;
    pulse_start();
    cyc = 0; lb = 0; maxpc = 0;
    while (!ERR && cyc < 6000) begin
      if (IMEM_REN && int'(PC_INS) > maxpc) maxpc = int'(PC_INS);
      if (LOAD_B) lb++;
      tick(); cyc++;
    end
    chk("overflow_err", {ERR, DONE, BUSY}, {1'b1, 1'b0, 1'b0});
    chk("overflow_last_pc", maxpc, 255);
    chk("overflow_loadb_pulses", lb, 255 * 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
